// File: rtl/l2_trace_pkg.sv
// l2_trace_pkg: opcode encoding and ASCII bus constants shared by the trace ingress stage
package l2_trace_pkg;
  typedef enum logic [2:0] {
    OP_DR = 3'd0,
    OP_DW = 3'd1,
    OP_IR = 3'd2,
    OP_SI = 3'd3,
    OP_SR = 3'd4,
    OP_SW = 3'd5,
    OP_SM = 3'd6
  } op_t;
  localparam logic [15:0] L1_OP_DR = 16'h4452;
  localparam logic [15:0] L1_OP_DW = 16'h4457;
  localparam logic [15:0] L1_OP_IR = 16'h4952;
  localparam logic [7:0]  SNP_OP_I = 8'h49;
  localparam logic [7:0]  SNP_OP_R = 8'h52;
  localparam logic [7:0]  SNP_OP_W = 8'h57;
  localparam logic [7:0]  SNP_OP_M = 8'h4D;
  localparam int          STAT_DROP = 7;
endpackage

// File: rtl/trace_bus_ingress_if.sv
// trace_bus_ingress_if: trace buses in, decoded request handshake out
interface trace_bus_ingress_if
  import l2_trace_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic              bus_strobe;
  logic [ADDR_W-1:0] l1_addr;
  logic [15:0]       l1_op;
  logic [ADDR_W-1:0] shared_addr;
  logic [7:0]        shared_op;
  logic              req_valid;
  logic              req_ready;
  op_t               req_op;
  logic [ADDR_W-1:0] req_addr;
  modport master (
    output bus_strobe, l1_addr, l1_op, shared_addr, shared_op, req_ready,
    input  req_valid, req_op, req_addr
  );
  modport slave (
    input  bus_strobe, l1_addr, l1_op, shared_addr, shared_op, req_ready,
    output req_valid, req_op, req_addr
  );
endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO with a separate occupancy count so full and empty never alias
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 35
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  // a pop frees the slot this cycle, so a push at full still lands
  assign do_push = push_i && (!full_o || do_pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= din_i;
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/trace_bus_ingress.sv
// trace_bus_ingress: decodes strobed L1/snoop ASCII ops into queued requests.
// Define TRACE_STATS_EN to add per-opcode and drop counters on stat_sel/stat_value.
module trace_bus_ingress
  import l2_trace_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  trace_bus_ingress_if.slave     bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow,
  output logic                   illegal,
  input  logic [2:0]             stat_sel,
  output logic [31:0]            stat_value
);
  localparam int W = 3 + ADDR_W;
  logic          l1_ok, sh_ok, push_req, bad_strobe, pop, full, empty, accept, drop;
  op_t           l1_code, sh_code, new_op;
  logic [W-1:0]  din, dout;
  logic          ovf_q, ill_q;
  // === keeps X/Z op bits from ever matching, so they decode as "none"
  always_comb begin
    l1_ok    = (bus.l1_op === L1_OP_DR) || (bus.l1_op === L1_OP_DW) || (bus.l1_op === L1_OP_IR);
    l1_code  = (bus.l1_op === L1_OP_DR) ? OP_DR : (bus.l1_op === L1_OP_DW) ? OP_DW : OP_IR;
    sh_ok    = (bus.shared_op === SNP_OP_I) || (bus.shared_op === SNP_OP_R) ||
               (bus.shared_op === SNP_OP_W) || (bus.shared_op === SNP_OP_M);
    sh_code  = (bus.shared_op === SNP_OP_I) ? OP_SI : (bus.shared_op === SNP_OP_R) ? OP_SR :
               (bus.shared_op === SNP_OP_W) ? OP_SW : OP_SM;
    new_op   = l1_ok ? l1_code : sh_code;
    push_req = bus.bus_strobe && (l1_ok ^ sh_ok);
    bad_strobe = bus.bus_strobe && !(l1_ok ^ sh_ok);
    din      = {new_op, l1_ok ? bus.l1_addr : bus.shared_addr};
    pop      = !empty && bus.req_ready;
    accept   = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end
  trace_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_req),
    .pop_i   (pop),
    .din_i   (din),
    .dout_o  (dout),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occupancy)
  );
  assign bus.req_valid = !empty;
  assign bus.req_op    = op_t'(dout[W-1:ADDR_W]);
  assign bus.req_addr  = dout[ADDR_W-1:0];
  assign overflow      = ovf_q;
  assign illegal       = ill_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | drop;
      ill_q <= ill_q | bad_strobe;
    end
  end
`ifdef TRACE_STATS_EN
  logic [31:0] stat_q [8];
  assign stat_value = stat_q[stat_sel];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) stat_q[i] <= '0;
    end else begin
      if (accept && stat_q[new_op] != '1) stat_q[new_op] <= stat_q[new_op] + 32'd1;
      if ((drop || bad_strobe) && stat_q[STAT_DROP] != '1) stat_q[STAT_DROP] <= stat_q[STAT_DROP] + 32'd1;
    end
  end
`else
  logic unused_stat;
  assign unused_stat = ^{stat_sel, accept};
  assign stat_value  = '0;
`endif
endmodule

// File: tb/tb_trace_bus_ingress.sv
// tb_trace_bus_ingress: directed scenarios with hand-computed expectations for trace_bus_ingress
module tb_trace_bus_ingress;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  occupancy;
  logic        overflow, illegal;
  logic [2:0]  stat_sel = 3'd0;
  logic [31:0] stat_value;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  trace_bus_ingress_if #(.ADDR_W(ADDR_W)) bus ();
  trace_bus_ingress #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .occupancy  (occupancy),
    .overflow   (overflow),
    .illegal    (illegal),
    .stat_sel   (stat_sel),
    .stat_value (stat_value)
  );
  task automatic idle();
    bus.bus_strobe = 1'b0;
    bus.l1_op = 'z;
    bus.shared_op = 'z;
    bus.l1_addr = '0;
    bus.shared_addr = '0;
    bus.req_ready = 1'b0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic strobe_l1(input logic [15:0] op, input logic [31:0] addr);
    bus.bus_strobe = 1'b1;
    bus.l1_op = op;
    bus.l1_addr = addr;
    bus.shared_op = 'z;
  endtask
  task automatic strobe_sh(input logic [7:0] op, input logic [31:0] addr);
    bus.bus_strobe = 1'b1;
    bus.shared_op = op;
    bus.shared_addr = addr;
    bus.l1_op = 'z;
  endtask
  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    if (bus.req_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", bus.req_valid); end total++;
    if (occupancy !== 4'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end total++;
    if ({overflow, illegal} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {overflow, illegal}); end total++;
    if (bus.req_op !== 3'd0 || bus.req_addr !== 32'h0) begin bad++; $display("FAIL reset_head got=%0d/%h exp=0/0", bus.req_op, bus.req_addr); end total++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_single();
    strobe_l1(16'h4452, 32'h0000_1000);
    step();
    idle();
    if (bus.req_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0h exp=1", bus.req_valid); end total++;
    if (bus.req_op !== 3'd0) begin bad++; $display("FAIL single_op got=%0d exp=0", bus.req_op); end total++;
    if (bus.req_addr !== 32'h1000) begin bad++; $display("FAIL single_addr got=%h exp=1000", bus.req_addr); end total++;
    if (occupancy !== 4'd1) begin bad++; $display("FAIL single_occ got=%0d exp=1", occupancy); end total++;
  endtask
  task automatic test_snoop_pop();
    strobe_sh(8'h4D, 32'hDEAD_BEE0);
    bus.req_ready = 1'b1;
    step();
    bus.bus_strobe = 1'b0;
    bus.shared_op = 'z;
    if (bus.req_op !== 3'd6 || bus.req_addr !== 32'hDEAD_BEE0) begin bad++; $display("FAIL snoop_head got=%0d/%h exp=6/deadbee0", bus.req_op, bus.req_addr); end total++;
    if (occupancy !== 4'd1) begin bad++; $display("FAIL snoop_occ got=%0d exp=1", occupancy); end total++;
    step();
    idle();
    if (occupancy !== 4'd0 || bus.req_valid !== 1'b0) begin bad++; $display("FAIL snoop_drain got=%0d/%0h exp=0/0", occupancy, bus.req_valid); end total++;
  endtask
  task automatic test_full_pushpop();
    logic [31:0] exp_addr;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      strobe_l1(16'h4952, 32'h200 + i);
      step();
    end
    if (occupancy !== 4'd8) begin bad++; $display("FAIL full_occ got=%0d exp=8", occupancy); end total++;
    strobe_l1(16'h4952, 32'h2FF);
    bus.req_ready = 1'b1;
    step();
    idle();
    if (occupancy !== 4'd8 || overflow !== 1'b0) begin bad++; $display("FAIL full_pp got=%0d/%0h exp=8/0", occupancy, overflow); end total++;
    bus.req_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_addr = (i < DEPTH - 1) ? 32'h201 + i : 32'h2FF;
      if (bus.req_valid !== 1'b1 || bus.req_op !== 3'd2 || bus.req_addr !== exp_addr) begin bad++; $display("FAIL full_drain%0d got=%0h/%0d/%h exp=1/2/%h", i, bus.req_valid, bus.req_op, bus.req_addr, exp_addr); end total++;
      step();
    end
    idle();
    if (occupancy !== 4'd0) begin bad++; $display("FAIL full_empty got=%0d exp=0", occupancy); end total++;
  endtask
  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      strobe_l1(16'h4457, 32'h100 + i);
      step();
    end
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0h exp=0", overflow); end total++;
    strobe_l1(16'h4457, 32'h1FF);
    step();
    idle();
    if (occupancy !== 4'd8 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0d/%0h exp=8/1", occupancy, overflow); end total++;
`ifdef TRACE_STATS_EN
    stat_sel = 3'd7;
    #1;
    if (stat_value !== 32'd1) begin bad++; $display("FAIL stat_drop got=%0d exp=1", stat_value); end total++;
    stat_sel = 3'd1;
    #1;
    if (stat_value !== 32'd8) begin bad++; $display("FAIL stat_dw got=%0d exp=8", stat_value); end total++;
`else
    if (stat_value !== 32'd0) begin bad++; $display("FAIL stat_tied got=%0d exp=0", stat_value); end total++;
`endif
    bus.req_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.req_op !== 3'd1 || bus.req_addr !== 32'h100 + i) begin bad++; $display("FAIL ovf_drain%0d got=%0d/%h exp=1/%h", i, bus.req_op, bus.req_addr, 32'h100 + i); end total++;
      step();
    end
    idle();
    if (occupancy !== 4'd0 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0d/%0h exp=0/1", occupancy, overflow); end total++;
  endtask
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      strobe_l1(16'h4952, 32'h300 + i);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      strobe_l1(16'h4452, 32'h400 + i);
      step();
    end
    idle();
    if (occupancy !== 4'd8 || overflow !== 1'b1) begin bad++; $display("FAIL stats_fill got=%0d/%0h exp=8/1", occupancy, overflow); end total++;
`ifdef TRACE_STATS_EN
    stat_sel = 3'd2;
    #1;
    if (stat_value !== 32'd3) begin bad++; $display("FAIL stat_ir got=%0d exp=3", stat_value); end total++;
    stat_sel = 3'd0;
    #1;
    if (stat_value !== 32'd5) begin bad++; $display("FAIL stat_dr got=%0d exp=5", stat_value); end total++;
    stat_sel = 3'd7;
    #1;
    if (stat_value !== 32'd1) begin bad++; $display("FAIL stat_drop2 got=%0d exp=1", stat_value); end total++;
`endif
  endtask
  task automatic test_illegal();
    do_reset();
    bus.bus_strobe = 1'b1;
    bus.l1_op = 16'h4452;
    bus.shared_op = 8'h49;
    step();
    idle();
    if (illegal !== 1'b1 || occupancy !== 4'd0 || bus.req_valid !== 1'b0) begin bad++; $display("FAIL ill_both got=%0h/%0d/%0h exp=1/0/0", illegal, occupancy, bus.req_valid); end total++;
    do_reset();
    if (illegal !== 1'b0) begin bad++; $display("FAIL ill_clear got=%0h exp=0", illegal); end total++;
    strobe_l1(16'h0000, 32'h55);
    step();
    idle();
    if (illegal !== 1'b1 || occupancy !== 4'd0) begin bad++; $display("FAIL ill_none got=%0h/%0d exp=1/0", illegal, occupancy); end total++;
    step();
    if (illegal !== 1'b1) begin bad++; $display("FAIL ill_sticky got=%0h exp=1", illegal); end total++;
  endtask
  task automatic test_back_to_back();
    logic [7:0] ops [3] = '{8'h52, 8'h57, 8'h49};
    logic [2:0] codes [3] = '{3'd4, 3'd5, 3'd3};
    do_reset();
    bus.req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strobe_sh(ops[i], 32'h500 + i);
      step();
      if (bus.req_op !== codes[i] || bus.req_addr !== 32'h500 + i || occupancy !== 4'd1) begin bad++; $display("FAIL b2b%0d got=%0d/%h/%0d exp=%0d/%h/1", i, bus.req_op, bus.req_addr, occupancy, codes[i], 32'h500 + i); end total++;
    end
    bus.bus_strobe = 1'b0;
    step();
    idle();
    if (occupancy !== 4'd0) begin bad++; $display("FAIL b2b_end got=%0d exp=0", occupancy); end total++;
  endtask
  task automatic test_midreset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      strobe_l1(16'h4457, 32'h600 + i);
      step();
    end
    strobe_l1(16'h4457, 32'h6FF);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    if (occupancy !== 4'd0 || bus.req_valid !== 1'b0) begin bad++; $display("FAIL mid_occ got=%0d/%0h exp=0/0", occupancy, bus.req_valid); end total++;
    if (bus.req_op !== 3'd0 || bus.req_addr !== 32'h0 || overflow !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL mid_state got=%0d/%h/%0h/%0h exp=0/0/0/0", bus.req_op, bus.req_addr, overflow, illegal); end total++;
    stat_sel = 3'd1;
    #1;
    if (stat_value !== 32'd0) begin bad++; $display("FAIL mid_stat got=%0d exp=0", stat_value); end total++;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    if (occupancy !== 4'd0) begin bad++; $display("FAIL mid_after got=%0d exp=0", occupancy); end total++;
  endtask
  initial begin
    test_reset();
    test_single();
    test_snoop_pop();
    test_full_pushpop();
    test_overflow();
    test_stats();
    test_illegal();
    test_back_to_back();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trace_bus_ingress.md
# trace_bus_ingress

Clocked ingress stage between the trace-file bus driver and the L2 cache controller. Samples the L1 and shared (snoop) address/operation buses on a strobe and decodes the ASCII operation codes into a compact opcode. Queues each decoded request in a FIFO. Presents requests to the controller over a valid/ready handshake.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2 to 64
- ADDR_W, 32, address width carried per entry
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- bus_strobe  in  1  one-cycle pulse marking a new command on the buses
- l1_addr  in  ADDR_W  L1 request address
- l1_op  in  16  L1 op, ASCII: "DR"=16'h4452, "DW"=16'h4457, "IR"=16'h4952
- shared_addr  in  ADDR_W  snoop address
- shared_op  in  8  snoop op, ASCII: "I"=8'h49, "R"=8'h52, "W"=8'h57, "M"=8'h4D
- req_valid  out  1  head entry available
- req_ready  in  1  controller accepts head entry
- req_op  out  3  decoded opcode of head entry (op_t)
- req_addr  out  ADDR_W  address of head entry
- occupancy  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky; a decoded command was dropped because the FIFO was full
- illegal  out  1  sticky; a strobe carried no legal op, or legal ops on both buses
- stat_sel  in  3  counter select (TRACE_STATS_EN only)
- stat_value  out  32  selected counter (TRACE_STATS_EN only)

## Operation
- Decode, combinational on the bus inputs: op_t = {OP_DR=0, OP_DW=1, OP_IR=2, OP_SI=3, OP_SR=4, OP_SW=5, OP_SM=6}. Any other value, including X/Z, is "none" for that bus.
- On bus_strobe with exactly one bus decoding legally, push {op, matching address}.
- On bus_strobe with none or both legal: no push; set illegal.
- On push while full with no simultaneous pop: drop the command; set overflow. Occupancy is unchanged.
- Pop when req_valid && req_ready.
- Push and pop in the same cycle: both succeed, including at full. Occupancy is unchanged.
- Pop when empty is impossible (req_valid=0). req_ready is ignored.
- Pointers wrap modulo DEPTH. Occupancy is held separately so full and empty are unambiguous.
- req_op and req_addr are X-free but don't-care while req_valid=0. They are driven from the head entry.
- overflow and illegal clear only on reset.
- Reset mid-operation discards all queued entries. No partial state survives.

## Timing
- Reset values: req_valid=0, occupancy=0, overflow=0, illegal=0, pointers=0, req_op=0, req_addr=0, stat counters=0.
- Latency: a strobe sampled at edge N on an empty FIFO gives req_valid=1 after edge N. There is no combinational bypass from the buses to req_*.
- Throughput: one push and one pop per cycle.
- req_valid stays high, with req_op/req_addr stable, until a pop occurs.
- The sticky flags assert on the edge that samples the offending strobe.
- bus_strobe held high for k cycles means k pushes.

## Configuration
- TRACE_STATS_EN defined: eight 32-bit saturating counters, incremented on accepted pushes.
  - stat_sel 0–6 counts per op_t.
  - stat_sel 7 counts drops, from both overflow and illegal events.
  - stat_value is a combinational read of counter[stat_sel].
  - Counters hold at 32'hFFFF_FFFF.
- TRACE_STATS_EN undefined: no counters; stat_sel is ignored and stat_value is tied to 0.

## Structure
- Package l2_trace_pkg holds:
  - op_t enum, 3 bits;
  - ASCII constants L1_OP_DR/DW/IR and SNP_OP_I/R/W/M;
  - STAT_DROP=7.
- Sub-module trace_fifo: parameterised DEPTH×(3+ADDR_W) synchronous FIFO with push/pop, full/empty and occupancy. Decode, sticky flags and stats stay in the top level.

## Test plan
- Reset, then strobe with l1_op=16'h4452, l1_addr=32'h0000_1000, shared_op=Z → next cycle req_valid=1, req_op=0, req_addr=32'h1000, occupancy=1.
- Strobe with shared_op=8'h4D, shared_addr=32'hDEAD_BEE0, l1_op=Z, req_ready=1 → req_op=6 for one cycle, then occupancy=0.
- req_ready=0, 9 strobes of "DW" at DEPTH=8 → occupancy=8, overflow=1, 8 entries drain in order.
- At full, strobe and req_ready=1 in the same cycle → occupancy stays 8, overflow stays 0, new entry is at the tail.
- Strobe with l1_op=16'h4452 and shared_op=8'h49 both set → no push, illegal=1. Strobe with l1_op=16'h0000 → illegal=1, occupancy=0.
- With TRACE_STATS_EN: 3 "IR" and 1 overflow → stat_sel=2 reads 3 and stat_sel=7 reads 1. Assert rst_n low mid-stream → all outputs and counters read 0 within the same cycle.
